// File: rtl/div_pkg.sv
// Shared types and constants for the 64/32 divider sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIV_LATENCY = 34;   // divider reset release to fin
    localparam int DVD_W       = 64;
    localparam int DVS_W       = 32;
    localparam int QUO_W       = 32;

    localparam logic [QUO_W-1:0] QUOT_SAT = 32'hFFFF_FFFF;

    // Quotient cannot fit in QUO_W bits when the dividend's upper half is
    // already at least the divisor. Caller excludes the zero-divisor case.
    function automatic logic quot_overflows(input logic [DVD_W-1:0] dvd,
                                            input logic [DVS_W-1:0] dvs);
        return (dvd[DVD_W-1:DVS_W] >= dvs);
    endfunction

endpackage

// File: rtl/div_sequencer.sv
// Request/response sequencer wrapped around the iterative 64/32 divider.
// Keeps the divider in reset except while an operation runs, handles
// divide-by-zero and quotient overflow without starting the divider, and
// raises a timeout if fin never arrives.
// Optional build macro: DIV_SEQ_FASTPATH_EN (divide-by-one shortcut).
module div_sequencer
    import div_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DVD_W-1:0]   req_dvdend,
    input  logic [DVS_W-1:0]   req_dvsor,
    output logic               div_reset,
    output logic [DVD_W-1:0]   div_dvdend,
    output logic [DVS_W-1:0]   div_dvsor,
    input  logic               div_fin,
    input  logic [QUO_W-1:0]   div_quot,
    input  logic [DVD_W-1:0]   div_rem,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [QUO_W-1:0]   rsp_quot,
    output logic [DVD_W-1:0]   rsp_rem,
    output logic               rsp_dbz,
    output logic               rsp_ovf,
    output logic               rsp_tmo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [DVD_W-1:0]   dvd_q, dvd_d;
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic [QUO_W-1:0]   quot_q, quot_d;
    logic [DVD_W-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               tmo_q, tmo_d;

    logic               dbz_s;
    logic               ovf_s;
    logic               fast_s;

    assign dbz_s     = (req_dvsor == 32'd0);
    assign ovf_s     = !dbz_s && quot_overflows(req_dvdend, req_dvsor);
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef DIV_SEQ_FASTPATH_EN
    assign fast_s = (req_dvsor == 32'd1) && (req_dvdend[DVD_W-1:DVS_W] == 32'd0);
`else
    assign fast_s = 1'b0;
`endif

    // Next-state, counter and response capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    dvd_d = req_dvdend;
                    dvs_d = req_dvsor;
                    dbz_d = dbz_s;
                    ovf_d = ovf_s;
                    tmo_d = 1'b0;
                    if (dbz_s || ovf_s) begin
                        quot_d  = QUOT_SAT;
                        rem_d   = req_dvdend;
                        state_d = DONE;
                    end else if (fast_s) begin
                        quot_d  = req_dvdend[QUO_W-1:0];
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        quot_d  = '0;
                        rem_d   = '0;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (div_fin) begin
                    quot_d  = div_quot;
                    rem_d   = div_rem;
                    state_d = DONE;
                end else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
                    tmo_d   = 1'b1;
                    quot_d  = '0;
                    rem_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, operand and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    // Control outputs decode the state flop; reset low forces the safe values
    // immediately rather than waiting for the next edge.
    assign req_ready  = reset && (state_q == IDLE);
    assign div_reset  = !reset || (state_q != RUN);
    assign rsp_valid  = reset && (state_q == DONE);

    assign div_dvdend = dvd_q;
    assign div_dvsor  = dvs_q;
    assign rsp_quot   = quot_q;
    assign rsp_rem    = rem_q;
    assign rsp_dbz    = dbz_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_tmo    = tmo_q;

endmodule
